fpu_offload_scheduler: RTL

//  In-order scheduler between the CORE-V-XIF issue/commit handshakes and the FPU model pipeline.

---
 rtl/fpu_offload_scheduler_if.sv | 29 ++
 rtl/fpu_offload_scheduler.sv | 86 ++++++++
 2 files changed

// File: rtl/fpu_offload_scheduler_if.sv
// fpu_offload_scheduler_if: accept, commit and dispatch handshakes between XIF front end, scheduler and FPU pipeline
interface fpu_offload_scheduler_if #(
  parameter int X_ID_WIDTH  = 4,
  parameter int QUEUE_DEPTH = 4,
  parameter int INSTR_WIDTH = 32
);
  logic                             flush;
  logic                             acc_valid;
  logic [INSTR_WIDTH-1:0]           acc_instr;
  logic [X_ID_WIDTH-1:0]            acc_id;
  logic                             acc_ready;
  logic                             commit_valid;
  logic [X_ID_WIDTH-1:0]            commit_id;
  logic                             commit_kill;
  logic                             disp_valid;
  logic [INSTR_WIDTH-1:0]           disp_instr;
  logic [X_ID_WIDTH-1:0]            disp_id;
  logic                             disp_ready;
  logic [$clog2(QUEUE_DEPTH+1)-1:0] q_count;
  logic                             err_commit;
  modport master (
    output flush, acc_valid, acc_instr, acc_id, commit_valid, commit_id, commit_kill, disp_ready,
    input  acc_ready, disp_valid, disp_instr, disp_id, q_count, err_commit
  );
  modport slave (
    input  flush, acc_valid, acc_instr, acc_id, commit_valid, commit_id, commit_kill, disp_ready,
    output acc_ready, disp_valid, disp_instr, disp_id, q_count, err_commit
  );
endinterface

// File: rtl/fpu_offload_scheduler.sv
// fpu_offload_scheduler: in-order queue that holds accepted FP instructions until commit/kill, then dispatches them
module fpu_offload_scheduler #(
  parameter int X_ID_WIDTH  = 4,
  parameter int QUEUE_DEPTH = 4,
  parameter int INSTR_WIDTH = 32
) (
  input logic                    ck,
  input logic                    rst_n,
  fpu_offload_scheduler_if.slave xif
);
  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam int CW = $clog2(QUEUE_DEPTH + 1);
  logic [QUEUE_DEPTH-1:0] valid_q, cmt_q, kill_q;
  logic [X_ID_WIDTH-1:0]  id_q    [QUEUE_DEPTH];
  logic [INSTR_WIDTH-1:0] instr_q [QUEUE_DEPTH];
  logic [PW-1:0]          head_q, tail_q, midx, j;
  logic [CW-1:0]          count_q;
  logic                   err_q, push, pop, hit, new_cmt, head_cmt, kill_ret;
  always_comb begin
    hit  = 1'b0;
    midx = '0;
    j    = '0;
    // scan youngest to oldest so the oldest matching entry is the one left in midx
    for (int i = QUEUE_DEPTH - 1; i >= 0; i--) begin
      j = head_q + PW'(i);
      if (xif.commit_valid && valid_q[j] && !cmt_q[j] && id_q[j] == xif.commit_id) begin
        hit  = 1'b1;
        midx = j;
      end
    end
  end
  assign head_cmt       = valid_q[head_q] & cmt_q[head_q];
  assign kill_ret       = head_cmt & kill_q[head_q];
  assign xif.disp_valid = head_cmt & ~kill_q[head_q];
  assign xif.disp_instr = instr_q[head_q];
  assign xif.disp_id    = id_q[head_q];
  assign xif.acc_ready  = count_q != CW'(QUEUE_DEPTH);
  assign xif.q_count    = count_q;
  assign xif.err_commit = err_q;
  assign push           = xif.acc_valid & xif.acc_ready;
  assign pop            = (xif.disp_valid & xif.disp_ready) | kill_ret;
  // a commit for the entry being accepted right now lands directly in the new entry
  assign new_cmt        = xif.commit_valid & ~hit & push & (xif.acc_id == xif.commit_id);
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      cmt_q   <= '0;
      kill_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
      for (int k = 0; k < QUEUE_DEPTH; k++) begin
        id_q[k]    <= '0;
        instr_q[k] <= '0;
      end
    end else if (xif.flush) begin
      valid_q <= '0;
      cmt_q   <= '0;
      kill_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (push) begin
        valid_q[tail_q] <= 1'b1;
        cmt_q[tail_q]   <= new_cmt;
        kill_q[tail_q]  <= new_cmt & xif.commit_kill;
        id_q[tail_q]    <= xif.acc_id;
        instr_q[tail_q] <= xif.acc_instr;
        tail_q          <= tail_q + 1'b1;
      end
      if (hit) begin
        cmt_q[midx]  <= 1'b1;
        kill_q[midx] <= xif.commit_kill;
      end
      if (pop) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + 1'b1;
      end
      count_q <= count_q + CW'(push) - CW'(pop);
      err_q   <= xif.commit_valid & ~hit & ~new_cmt;
    end
  end
endmodule
